// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - IF/ID/EXE/MEM/WB sequencer for the RFplusALU datapath
// Owns IR, PSW and the memory-handshake timeout; all strobes are decoded from (State, IR).
module multicycle_ctrl #(
   parameter int DW       = 16,
   parameter int WAIT_MAX = 15
) (
   input  logic          clk,
   input  logic          Reset,
   input  logic [DW-1:0] MemRdata,
   input  logic          MemReady,
   input  logic          C,
   input  logic          Z,
   input  logic          N,
   output logic [10:0]   Ins,
   output logic          WBRF,
   output logic          WBresource,
   output logic          RBresource,
   output logic          OprandB,
   output logic          LI,
   output logic          ALUop,
   output logic          Flag,
   output logic          PSW_C,
   output logic          MemRead,
   output logic          MemWrite,
   output logic          IorD,
   output logic          PCWrite,
   output logic          PCsrc,
   output logic          Halted,
   output logic          BusErr,
   output logic          Illegal,
   output logic [2:0]    State
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EXE  = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   localparam logic [4:0] OP_ALU = 5'b00000;
   localparam logic [4:0] OP_LHI = 5'b00001;
   localparam logic [4:0] OP_LLI = 5'b00010;
   localparam logic [4:0] OP_LDR = 5'b00011;
   localparam logic [4:0] OP_STR = 5'b00100;
   localparam logic [4:0] OP_B   = 5'b00101;
   localparam logic [4:0] OP_BEQ = 5'b00110;
   localparam logic [4:0] OP_BCS = 5'b00111;
   localparam logic [4:0] OP_HLT = 5'b11111;

   localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

   state_t        state;
   state_t        state_nx;
   logic [DW-1:0] ir;
   logic [2:0]    psw;
   logic [7:0]    wait_cnt;
   logic          bus_err_q;
   logic [4:0]    op;
   logic          legal;
   logic          wait_active;
   logic          timeout;
   logic [2:0]    flag_mask;
   logic          taken;

   assign op          = ir[DW-1 -: 5];
   assign legal       = (op <= OP_BCS);
   assign wait_active = (state == S_IF) || (state == S_MEM);
   // The limit cycle itself still honours a late MemReady; only a miss there aborts.
   assign timeout     = wait_active && !MemReady && (wait_cnt == WAIT_LAST);

   // PSW is {C,Z,N}; branches test the stored flags, never the live ALU outputs.
   always_comb begin
      flag_mask = 3'b000;
      case (op)
         OP_BEQ:  flag_mask = 3'b010;
         OP_BCS:  flag_mask = 3'b100;
         default: flag_mask = 3'b000;
      endcase
   end
   assign taken = (op == OP_B) || (|(psw & flag_mask));

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state     <= S_IF;
         ir        <= '0;
         psw       <= '0;
         wait_cnt  <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state     <= state_nx;
         bus_err_q <= timeout;
         if (state == S_IF && MemReady)
            ir <= MemRdata;
         if (state == S_EXE && op == OP_ALU)
            psw <= {C, Z, N};
         if (wait_active && !MemReady && !timeout)
            wait_cnt <= wait_cnt + 8'd1;
         else
            wait_cnt <= '0;
      end
   end

   always_comb begin
      state_nx   = state;
      WBRF       = 1'b0;
      WBresource = 1'b0;
      RBresource = 1'b0;
      OprandB    = 1'b0;
      LI         = 1'b0;
      ALUop      = 1'b0;
      Flag       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IorD       = 1'b0;
      PCWrite    = 1'b0;
      PCsrc      = 1'b0;
      Halted     = 1'b0;
      Illegal    = 1'b0;
      // Outputs are held low while Reset is asserted, even though state already reads IF.
      if (Reset) begin
         case (state)
            S_IF: begin
               MemRead = 1'b1;
               if (MemReady) begin
                  PCWrite  = 1'b1;
                  state_nx = S_ID;
               end else if (timeout) begin
                  state_nx = S_IF;
               end
            end
            S_ID: begin
               if (op == OP_HLT) begin
                  state_nx = S_HALT;
               end else if (legal) begin
                  state_nx = S_EXE;
               end else begin
                  Illegal  = 1'b1;
                  state_nx = S_IF;
               end
            end
            S_EXE: begin
               state_nx = S_IF;
               case (op)
                  OP_ALU: begin
                     {ALUop, Flag} = ir[1:0];
                     state_nx      = S_WB;
                  end
                  OP_LHI: begin
                     RBresource = 1'b1;
                     LI         = 1'b1;
                     state_nx   = S_WB;
                  end
                  OP_LLI: state_nx = S_WB;
                  OP_LDR: begin
                     OprandB  = 1'b1;
                     state_nx = S_MEM;
                  end
                  OP_STR: begin
                     OprandB    = 1'b1;
                     RBresource = 1'b1;
                     state_nx   = S_MEM;
                  end
                  OP_B, OP_BEQ, OP_BCS: begin
                     PCWrite = taken;
                     PCsrc   = taken;
                  end
                  default: state_nx = S_IF;
               endcase
            end
            S_MEM: begin
               IorD = 1'b1;
               if (op == OP_LDR)
                  MemRead = 1'b1;
               if (op == OP_STR) begin
                  MemWrite   = 1'b1;
                  RBresource = 1'b1;
               end
               if (MemReady)
                  state_nx = (op == OP_LDR) ? S_WB : S_IF;
               else if (timeout)
                  state_nx = S_IF;
            end
            S_WB: begin
               WBRF       = 1'b1;
               WBresource = (op == OP_LDR);
               state_nx   = S_IF;
            end
            S_HALT: Halted = 1'b1;
            default: state_nx = S_IF;
         endcase
      end
   end

   assign Ins    = ir[10:0];
   assign PSW_C  = psw[2];
   assign BusErr = bus_err_q;
   assign State  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        Reset;
   logic [15:0] MemRdata;
   logic        MemReady;
   logic        C, Z, N;
   logic [10:0] Ins;
   logic        WBRF, WBresource, RBresource, OprandB, LI, ALUop, Flag, PSW_C;
   logic        MemRead, MemWrite, IorD, PCWrite, PCsrc, Halted, BusErr, Illegal;
   logic [2:0]  State;

   multicycle_ctrl #(.DW(16), .WAIT_MAX(15)) dut (
      .clk(clk), .Reset(Reset), .MemRdata(MemRdata), .MemReady(MemReady),
      .C(C), .Z(Z), .N(N), .Ins(Ins), .WBRF(WBRF), .WBresource(WBresource),
      .RBresource(RBresource), .OprandB(OprandB), .LI(LI), .ALUop(ALUop),
      .Flag(Flag), .PSW_C(PSW_C), .MemRead(MemRead), .MemWrite(MemWrite),
      .IorD(IorD), .PCWrite(PCWrite), .PCsrc(PCsrc), .Halted(Halted),
      .BusErr(BusErr), .Illegal(Illegal), .State(State)
   );

   always #5 clk = ~clk;

   localparam logic [15:0] IL = 16'h0001, BE = 16'h0002, HA = 16'h0004, PS = 16'h0008;
   localparam logic [15:0] PW = 16'h0010, IO = 16'h0020, MW = 16'h0040, MR = 16'h0080;
   localparam logic [15:0] PC = 16'h0100, FL = 16'h0200, AO = 16'h0400, LIb = 16'h0800;
   localparam logic [15:0] OB = 16'h1000, RB = 16'h2000, WR = 16'h4000, WB = 16'h8000;
   localparam logic [2:0]  SIF = 3'd0, SID = 3'd1, SEX = 3'd2, SME = 3'd3, SWB = 3'd4, SHA = 3'd5;

   typedef struct {
      logic [29:0] vec;
      int          step;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   step     = 0;

   wire [29:0] act = {State, Ins, WBRF, WBresource, RBresource, OprandB, LI, ALUop, Flag,
                      PSW_C, MemRead, MemWrite, IorD, PCWrite, PCsrc, Halted, BusErr, Illegal};

   function automatic logic [29:0] V(input logic [2:0] st, input logic [10:0] ins, input logic [15:0] fl);
      return {st, ins, fl};
   endfunction

   task automatic cyc(input logic rst, input logic rdy, input logic [15:0] rd,
                      input logic [2:0] czn, input logic [29:0] e);
      exp_t x;
      @(posedge clk);
      #1;
      Reset     = rst;
      MemReady  = rdy;
      MemRdata  = rd;
      {C, Z, N} = czn;
      step++;
      x.vec  = e;
      x.step = step;
      exp_q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t x;
         x = exp_q.pop_front();
         checks++;
         if (act !== x.vec) begin
            failures++;
            $display("FAIL step%0d outputs: got state=%0d ins=%h flags=%h, want state=%0d ins=%h flags=%h",
                     x.step, act[29:27], act[26:16], act[15:0], x.vec[29:27], x.vec[26:16], x.vec[15:0]);
         end
      end
   end

   initial begin
      Reset = 1'b0; MemReady = 1'b0; MemRdata = '0; {C, Z, N} = 3'b000;
      cyc(0, 0, 16'h0000, 3'b000, V(SIF, 11'h000, 16'h0));
      cyc(0, 1, 16'h0000, 3'b111, V(SIF, 11'h000, 16'h0));
      // ADD: PSW <= {0,1,0}
      cyc(1, 1, 16'h0104, 3'b000, V(SIF, 11'h000, MR|PW));
      cyc(1, 0, 16'h0000, 3'b000, V(SID, 11'h104, 16'h0));
      cyc(1, 0, 16'h0000, 3'b010, V(SEX, 11'h104, 16'h0));
      cyc(1, 0, 16'h0000, 3'b000, V(SWB, 11'h104, WB));
      // ADC with C=1
      cyc(1, 1, 16'h0105, 3'b000, V(SIF, 11'h104, MR|PW));
      cyc(1, 0, 16'h0000, 3'b000, V(SID, 11'h105, 16'h0));
      cyc(1, 0, 16'h0000, 3'b100, V(SEX, 11'h105, FL));
      cyc(1, 0, 16'h0000, 3'b000, V(SWB, 11'h105, WB|PC));
      // SBB: PSW <= {0,0,1}
      cyc(1, 1, 16'h0107, 3'b000, V(SIF, 11'h105, MR|PW|PC));
      cyc(1, 0, 16'h0000, 3'b000, V(SID, 11'h107, PC));
      cyc(1, 0, 16'h0000, 3'b001, V(SEX, 11'h107, AO|FL|PC));
      cyc(1, 0, 16'h0000, 3'b000, V(SWB, 11'h107, WB));
      // LHI {3'd1,8'h55}
      cyc(1, 1, 16'h0955, 3'b000, V(SIF, 11'h107, MR|PW));
      cyc(1, 0, 16'h0000, 3'b000, V(SID, 11'h155, 16'h0));
      cyc(1, 0, 16'h0000, 3'b000, V(SEX, 11'h155, LIb|RB));
      cyc(1, 0, 16'h0000, 3'b000, V(SWB, 11'h155, WB));
      // LLI {3'd2,8'h44}
      cyc(1, 1, 16'h1244, 3'b000, V(SIF, 11'h155, MR|PW));
      cyc(1, 0, 16'h0000, 3'b000, V(SID, 11'h244, 16'h0));
      cyc(1, 0, 16'h0000, 3'b000, V(SEX, 11'h244, 16'h0));
      cyc(1, 0, 16'h0000, 3'b000, V(SWB, 11'h244, WB));
      // LDR with MemReady delayed 3 cycles in MEM
      cyc(1, 1, 16'h1A0A, 3'b000, V(SIF, 11'h244, MR|PW));
      cyc(1, 0, 16'h0000, 3'b000, V(SID, 11'h20A, 16'h0));
      cyc(1, 0, 16'h0000, 3'b000, V(SEX, 11'h20A, OB));
      for (int i = 0; i < 3; i++)
         cyc(1, 0, 16'h0000, 3'b000, V(SME, 11'h20A, MR|IO));
      cyc(1, 1, 16'h0000, 3'b000, V(SME, 11'h20A, MR|IO));
      cyc(1, 0, 16'h0000, 3'b000, V(SWB, 11'h20A, WB|WR));
      // STR
      cyc(1, 1, 16'h230C, 3'b000, V(SIF, 11'h20A, MR|PW));
      cyc(1, 0, 16'h0000, 3'b000, V(SID, 11'h30C, 16'h0));
      cyc(1, 0, 16'h0000, 3'b000, V(SEX, 11'h30C, OB|RB));
      cyc(1, 1, 16'h0000, 3'b000, V(SME, 11'h30C, MW|IO|RB));
      // BEQ with stored Z=0, live Z=1: not taken
      cyc(1, 1, 16'h3010, 3'b000, V(SIF, 11'h30C, MR|PW));
      cyc(1, 0, 16'h0000, 3'b000, V(SID, 11'h010, 16'h0));
      cyc(1, 0, 16'h0000, 3'b010, V(SEX, 11'h010, 16'h0));
      // SUB: PSW <= {1,1,0}
      cyc(1, 1, 16'h0102, 3'b000, V(SIF, 11'h010, MR|PW));
      cyc(1, 0, 16'h0000, 3'b000, V(SID, 11'h102, 16'h0));
      cyc(1, 0, 16'h0000, 3'b110, V(SEX, 11'h102, AO));
      cyc(1, 0, 16'h0000, 3'b000, V(SWB, 11'h102, WB|PC));
      // BEQ with stored Z=1, live Z=0: taken
      cyc(1, 1, 16'h3010, 3'b000, V(SIF, 11'h102, MR|PW|PC));
      cyc(1, 0, 16'h0000, 3'b000, V(SID, 11'h010, PC));
      cyc(1, 0, 16'h0000, 3'b000, V(SEX, 11'h010, PW|PS|PC));
      // Illegal opcode 01000
      cyc(1, 1, 16'h4000, 3'b000, V(SIF, 11'h010, MR|PW|PC));
      cyc(1, 0, 16'h0000, 3'b000, V(SID, 11'h000, IL|PC));
      // Fetch timeout: 15 wait cycles, then BusErr pulse back in IF
      for (int i = 0; i < 15; i++)
         cyc(1, 0, 16'hFFFF, 3'b000, V(SIF, 11'h000, MR|PC));
      cyc(1, 0, 16'hFFFF, 3'b000, V(SIF, 11'h000, MR|PC|BE));
      // STR aborted by reset while waiting in MEM
      cyc(1, 1, 16'h230C, 3'b000, V(SIF, 11'h000, MR|PW|PC));
      cyc(1, 0, 16'h0000, 3'b000, V(SID, 11'h30C, PC));
      cyc(1, 0, 16'h0000, 3'b000, V(SEX, 11'h30C, OB|RB|PC));
      cyc(1, 0, 16'h0000, 3'b000, V(SME, 11'h30C, MW|IO|RB|PC));
      cyc(0, 1, 16'h0000, 3'b000, V(SIF, 11'h000, 16'h0));
      // MemReady on the limit cycle wins: no BusErr
      for (int i = 0; i < 14; i++)
         cyc(1, 0, 16'h0000, 3'b000, V(SIF, 11'h000, MR));
      cyc(1, 1, 16'hF800, 3'b000, V(SIF, 11'h000, MR|PW));
      cyc(1, 0, 16'h0000, 3'b000, V(SID, 11'h000, 16'h0));
      // HLT stays halted until reset
      for (int i = 0; i < 3; i++)
         cyc(1, 1, 16'h0104, 3'b111, V(SHA, 11'h000, HA));
      cyc(0, 1, 16'h0000, 3'b000, V(SIF, 11'h000, 16'h0));
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle sequencer for the RFplusALU register-file/ALU datapath in the MulticycleRISC core.
- Owns the instruction register (IR), the PSW flag register (C/Z/N) and the IF/ID/EXE/MEM/WB state machine.
- Decodes IR[15:11] and drives every RFplusALU control input, plus memory and PC control.
- Bounds every memory handshake with a wait-timeout counter.

Parameters:
DW, 16, instruction/data width
WAIT_MAX, 15, max cycles waiting on MemReady before bus-error abort (1..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous, active-low reset
MemRdata  input  DW  memory read data (instruction fetch source)
MemReady  input  1  memory access complete this cycle
C  input  1  ALU carry from RFplusALU EXE stage
Z  input  1  ALU zero from RFplusALU EXE stage
N  input  1  ALU negative from RFplusALU EXE stage
Ins  output  11  IR[10:0] to RFplusALU
WBRF  output  1  register-file write enable
WBresource  output  1  write-back select: 0=WBData path, 1=MEMData
RBresource  output  1  read-port B select: 0=Rn (Ins[4:2]), 1=Rd (Ins[10:8])
OprandB  output  1  ALU operand B: 0=Rn, 1=zero-extended Ins[4:0]
LI  output  1  1=LHI form {Ins[7:0],DataB}, 0=LLI form {8'b0,Ins[7:0]}
ALUop  output  1  0=add, 1=subtract
Flag  output  1  carry-in enable (ADC/SBB)
PSW_C  output  1  stored carry flag
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IorD  output  1  address select: 0=PC, 1=ALU Sum
PCWrite  output  1  PC update strobe
PCsrc  output  1  0=PC+1, 1=PC+sext(Ins[10:0])
Halted  output  1  core halted
BusErr  output  1  one-cycle pulse on handshake timeout
Illegal  output  1  one-cycle pulse on undefined opcode
State  output  3  current state encoding (debug)

Behaviour:
- Encoding: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5. Values 6 and 7 are unreachable and go to IF.
- Reset low, asynchronous:
  - State=IF; IR=0; PSW={C,Z,N}=0; wait counter=0.
  - Every output is 0, including pulses.
  - On release, fetch starts at the first rising edge.
- All control outputs are combinational from (State, IR) and stay stable for the whole state.
- Opcodes (IR[15:11]):
  - 00000 ALU: funct IR[1:0] drives {ALUop,Flag}; 00=ADD, 01=ADC, 10=SUB, 11=SBB.
  - 00001 LHI; 00010 LLI; 00011 LDR; 00100 STR.
  - 00101 B; 00110 BEQ (taken if Z); 00111 BCS (taken if C).
  - 11111 HLT; all others illegal.
- IF: MemRead=1, IorD=0.
  - MemReady=1: IR<=MemRdata, PCWrite=1, PCsrc=0, go to ID.
- ID: decode; Ins is valid for RFplusALU register read.
  - Legal opcode: go to EXE.
  - HLT: go to HALT.
  - Illegal: Illegal=1 for one cycle, go to IF.
- EXE:
  - ALU: OprandB=0, RBresource=0; PSW<={C,Z,N} at the end of the cycle; go to WB.
  - LHI: RBresource=1, LI=1; go to WB.
  - LLI: LI=0; go to WB.
  - LDR: OprandB=1; go to MEM.
  - STR: OprandB=1, RBresource=1; go to MEM.
  - B/BEQ/BCS: if taken, PCWrite=1, PCsrc=1; go to IF.
- MEM: IorD=1. LDR drives MemRead=1; STR drives MemWrite=1 and RBresource=1.
  - Waits for MemReady. LDR then goes to WB; STR goes to IF.
- WB: WBRF=1, then go to IF.
  - WBresource=1 for LDR, 0 for ALU/LHI/LLI.
- HALT: Halted=1; all other strobes 0. Only Reset exits.
- Cycle counts with MemReady tied high:
  - ALU/LHI/LLI: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Branch: 3 cycles.
- Wait counter:
  - Clears on entry to IF or MEM.
  - Increments each cycle in IF/MEM while MemReady=0.
  - On reaching WAIT_MAX with MemReady still 0: BusErr=1 for one cycle, go to IF, no IR/PC/RF write.
  - A MemReady arriving in the same cycle as the limit wins (no error).
- PSW changes only in EXE of ALU ops. PSW_C=PSW.C. Branches use the stored PSW, not the live C/Z.
- Reset asserted mid-instruction: immediate abort; no partial WBRF/MemWrite is issued after assertion.

Test Plan:
- Reset, then fetch ADD (IR=0x0000+regs), MemReady high: State 0,1,2,4,0 over 4 cycles; WBRF=1 only in cycle 4; PSW latched from {C,Z,N}.
- ADC then SBB with C input=1 on the ADC: ADC gives ALUop=0, Flag=1; PSW_C=1 thereafter; SBB gives ALUop=1, Flag=1.
- LHI Ins={3'd1,8'h55}: EXE has LI=1, RBresource=1; WB has WBRF=1, WBresource=0. LLI 8'h44 has LI=0.
- LDR with MemReady delayed 3 cycles in MEM: MEM held 4 cycles with MemRead=1, IorD=1; WB has WBresource=1. STR asserts MemWrite with no WBRF.
- BEQ with PSW.Z=0: no PCWrite in EXE. With Z=1: PCWrite=1, PCsrc=1. Opcode 01000 gives an Illegal pulse and returns to IF after 2 cycles.
- MemReady held 0 in IF: BusErr pulses after exactly 15 wait cycles and IR is unchanged. HLT sets Halted=1 until Reset. Reset asserted in MEM during STR gives MemWrite=0 immediately.
